// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive handshake FSM feeding a first-word-fall-through FIFO of characters plus error flags; ports: clk, rst_n, en, uart_* receiver side, rd_* read port, empty/full/count/overflow status, clr_overflow; optional timeout output under UART_RX_FIFO_TIMEOUT_EN
module uart_rx_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int WIDTH          = 9,
  parameter int ACK_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [WIDTH-1:0]      uart_data,
  input  logic                  uart_charreceived,
  input  logic                  uart_frameerror,
  input  logic                  uart_parityerror,
  input  logic                  uart_overrun,
  output logic                  uart_rd,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_fe,
  output logic                  rd_pe,
  output logic                  rd_ovr,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
`ifdef UART_RX_FIFO_TIMEOUT_EN
  output logic                  timeout,
`endif
  input  logic                  clr_overflow
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int AW = $clog2(ACK_CYCLES+1);
  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_CLR} state_t;
  state_t state;
  logic cr_s1, cr_s2;
  logic [WIDTH+2:0] cap;
  logic [WIDTH+2:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] ack_cnt;
  logic push, pop, wr;
  assign empty = count == '0;
  assign full = count == (DEPTH_LOG2+1)'(DEPTH);
  assign push = en && state == CAPTURE;
  assign pop = en && rd_en && !empty;
  // a push into a full FIFO only lands if the head leaves in the same cycle
  assign wr = push && (!full || pop);
  // gating on empty keeps the read port at zero after reset and flush
  assign {rd_ovr, rd_pe, rd_fe, rd_data} = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cr_s2, cr_s1} <= 2'b00;
    else {cr_s2, cr_s1} <= {cr_s1, uart_charreceived};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      uart_rd <= 1'b0;
      ack_cnt <= '0;
      cap <= '0;
    end else if (!en) begin
      state <= IDLE;
      uart_rd <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cr_s2) begin
          state <= CAPTURE;
          cap <= {uart_overrun, uart_parityerror, uart_frameerror, uart_data};
        end
        CAPTURE: begin
          state <= ACK;
          uart_rd <= 1'b1;
          ack_cnt <= AW'(ACK_CYCLES-1);
        end
        ACK: if (ack_cnt == '0) begin
          state <= WAIT_CLR;
          uart_rd <= 1'b0;
        end else ack_cnt <= ack_cnt - AW'(1);
        default: if (!cr_s2) state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= cap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else if (!en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (wr && !pop) count <= count + (DEPTH_LOG2+1)'(1);
      else if (!wr && pop) count <= count - (DEPTH_LOG2+1)'(1);
      if (push && !wr) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= (wr || pop || empty || !en) ? '0 : (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + TW'(1);
      timeout <= tcnt == TW'(TIMEOUT_CYCLES) && !empty;
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 0, rst_n = 0, en = 1;
  logic [8:0] uart_data = 0;
  logic uart_charreceived = 0, uart_frameerror = 0, uart_parityerror = 0, uart_overrun = 0;
  logic uart_rd, rd_en = 0, clr_overflow = 0;
  logic [8:0] rd_data;
  logic rd_fe, rd_pe, rd_ovr, empty, full, overflow;
  logic [4:0] count;
`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic timeout;
`endif
  int checks = 0, errors = 0;
  uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(9), .ACK_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .uart_data(uart_data),
    .uart_charreceived(uart_charreceived), .uart_frameerror(uart_frameerror),
    .uart_parityerror(uart_parityerror), .uart_overrun(uart_overrun), .uart_rd(uart_rd),
    .rd_en(rd_en), .rd_data(rd_data), .rd_fe(rd_fe), .rd_pe(rd_pe), .rd_ovr(rd_ovr),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
`ifdef UART_RX_FIFO_TIMEOUT_EN
    .timeout(timeout),
`endif
    .clr_overflow(clr_overflow));
  always #5 clk = ~clk;

  // Receiver model: raise charreceived, wait for uart_rd, drop it, measure the strobe.
  // act bit0 drives rd_en and bit1 drives clr_overflow on the edge that writes the entry.
  task automatic send_char(input logic [8:0] d, input logic fe, pe, ovr, input logic [1:0] act,
                           output int lat, output int hi);
    @(negedge clk);
    uart_data = d; uart_frameerror = fe; uart_parityerror = pe; uart_overrun = ovr;
    uart_charreceived = 1;
    lat = 0;
    while (!uart_rd && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 3) {clr_overflow, rd_en} = act;
      if (lat == 4) {clr_overflow, rd_en} = 2'b00;
    end
    checks++;
    if (!uart_rd) begin errors++; $display("FAIL uart_rd_wait: uart_rd=%b after %0d cycles, required 1", uart_rd, lat); end
    uart_charreceived = 0;
    hi = 0;
    while (uart_rd && hi < 20) begin @(negedge clk); hi++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic pop_one();
    @(negedge clk); rd_en = 1;
    @(negedge clk); rd_en = 0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({uart_rd, rd_data, rd_fe, rd_pe, rd_ovr, full, count, overflow, empty} !== {19'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset: uart_rd=%b rd_data=%h flags=%b%b%b full=%b count=%0d ovf=%b empty=%b, required all 0 and empty=1",
               uart_rd, rd_data, rd_fe, rd_pe, rd_ovr, full, count, overflow, empty);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat, hi;
    send_char(9'h0A5, 0, 0, 0, 2'b00, lat, hi);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL single_latency: uart_rd rose after edge %0d, required 4", lat); end
    checks++;
    if (hi !== 2) begin errors++; $display("FAIL single_ack_len: uart_rd high %0d cycles, required 2", hi); end
    checks++;
    if ({empty, count, rd_data, rd_fe, rd_pe, rd_ovr} !== {1'b0, 5'd1, 9'h0A5, 3'b000}) begin
      errors++;
      $display("FAIL single_head: empty=%b count=%0d data=%h flags=%b%b%b, required 0 1 0a5 000",
               empty, count, rd_data, rd_fe, rd_pe, rd_ovr);
    end
    pop_one();
  endtask

  task automatic test_error_flags();
    int lat, hi;
    send_char(9'h1FF, 1, 1, 0, 2'b00, lat, hi);
    checks++;
    if ({rd_data, rd_fe, rd_pe, rd_ovr} !== {9'h1FF, 3'b110}) begin
      errors++; $display("FAIL flags_fe_pe: data=%h fe=%b pe=%b ovr=%b, required 1ff 1 1 0", rd_data, rd_fe, rd_pe, rd_ovr);
    end
    pop_one();
    checks++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL flags_pop: empty=%b count=%0d, required 1 0", empty, count);
    end
    send_char(9'h055, 0, 0, 1, 2'b00, lat, hi);
    checks++;
    if ({rd_data, rd_fe, rd_pe, rd_ovr} !== {9'h055, 3'b001}) begin
      errors++; $display("FAIL flags_ovr: data=%h fe=%b pe=%b ovr=%b, required 055 0 0 1", rd_data, rd_fe, rd_pe, rd_ovr);
    end
    pop_one();
  endtask

  task automatic test_fill();
    int lat, hi;
    for (int i = 0; i < 16; i++) send_char(9'(i), 0, 0, 0, 2'b00, lat, hi);
    checks++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      errors++; $display("FAIL fill_full: full=%b count=%0d ovf=%b, required 1 16 0", full, count, overflow);
    end
    send_char(9'h0AA, 0, 0, 0, 2'b10, lat, hi);
    checks++;
    if ({hi, overflow, count} !== {32'd2, 1'b1, 5'd16}) begin
      errors++; $display("FAIL fill_drop: ack=%0d ovf=%b count=%0d, required 2 1 16", hi, overflow, count);
    end
    @(negedge clk); clr_overflow = 1;
    @(negedge clk); clr_overflow = 0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: ovf=%b, required 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (rd_data !== 9'(i)) begin errors++; $display("FAIL fill_order: entry %0d data=%h, required %h", i, rd_data, 9'(i)); end
      rd_en = 1;
      @(negedge clk); rd_en = 0;
    end
    checks++;
    if ({empty, count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL fill_drain: empty=%b count=%0d, required 1 0", empty, count); end
  endtask

  task automatic test_full_push_pop();
    int lat, hi;
    for (int i = 0; i < 16; i++) send_char(9'h100 + 9'(i), 0, 0, 0, 2'b00, lat, hi);
    send_char(9'h155, 0, 0, 0, 2'b01, lat, hi);
    checks++;
    if ({count, full, overflow, rd_data} !== {5'd16, 1'b1, 1'b0, 9'h101}) begin
      errors++; $display("FAIL fullpp_state: count=%0d full=%b ovf=%b head=%h, required 16 1 0 101", count, full, overflow, rd_data);
    end
    repeat (15) pop_one();
    checks++;
    if ({count, rd_data} !== {5'd1, 9'h155}) begin
      errors++; $display("FAIL fullpp_last: count=%0d data=%h, required 1 155", count, rd_data);
    end
    pop_one();
  endtask

  task automatic test_reset_enable();
    int lat, hi;
    @(negedge clk);
    uart_data = 9'h033; uart_charreceived = 1;
    lat = 0;
    while (!uart_rd && lat < 20) begin @(negedge clk); lat++; end
    rst_n = 0;
    #1;
    checks++;
    if ({uart_rd, empty, count} !== {1'b0, 1'b1, 5'd0}) begin
      errors++; $display("FAIL reset_in_ack: uart_rd=%b empty=%b count=%0d, required 0 1 0", uart_rd, empty, count);
    end
    uart_charreceived = 0;
    @(negedge clk); rst_n = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) send_char(9'h010 + 9'(i), 0, 0, 0, 2'b00, lat, hi);
    checks++;
    if ({count, rd_data} !== {5'd5, 9'h010}) begin
      errors++; $display("FAIL after_reset: count=%0d head=%h, required 5 010", count, rd_data);
    end
    en = 0;
    @(negedge clk);
    checks++;
    if ({count, empty, full, overflow, uart_rd} !== {5'd0, 1'b1, 3'b000}) begin
      errors++; $display("FAIL en_flush: count=%0d empty=%b full=%b ovf=%b uart_rd=%b, required 0 1 0 0 0",
                         count, empty, full, overflow, uart_rd);
    end
    en = 1;
    @(negedge clk);
  endtask

`ifdef UART_RX_FIFO_TIMEOUT_EN
  task automatic test_timeout();
    int lat, hi;
    send_char(9'h07E, 0, 0, 0, 2'b00, lat, hi);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: timeout=%b, required 0", timeout); end
    repeat (12) @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: timeout=%b, required 1", timeout); end
    pop_one();
    @(negedge clk);
    checks++;
    if ({timeout, empty} !== 2'b01) begin errors++; $display("FAIL timeout_clear: timeout=%b empty=%b, required 0 1", timeout, empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_error_flags();
    test_fill();
    test_full_push_pop();
    test_reset_enable();
`ifdef UART_RX_FIFO_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
